inst_rom_bridge: RTL
====================

# inst_rom_bridge

Responder for the core's instruction-ROM port. It serves word fetches issued by the IF stage from a byte-wide, fixed-latency external ROM. Each fetched word goes into a one-entry line buffer. On a miss the block raises a stall request that drives the PC stall input until the word is assembled. It sits between the IF stage and the board ROM/flash pins.

## Interface
Parameters:
- `MEM_ADDR_W`, default 20: external ROM byte-address width.
- `WAIT_CYCLES`, default 2: wait states per byte read, 0..15.

Ports:
- `clk`, in, 1: core clock.
- `rst`, in, 1: reset, synchronous and active-low (0 = reset).
- `rom_en`, in, 1: fetch enable from the IF stage.
- `rom_write_en`, in, 4 (`MEM_SEL_BUS`): byte write enables. The ROM is read-only, so any non-zero value is an error.
- `rom_addr`, in, 32 (`ADDR_BUS`): fetch byte address.
- `rom_write_data`, in, 32 (`DATA_BUS`): ignored.
- `rom_read_data`, out, 32: instruction word.
- `stall_req`, out, 1: fetch not ready; OR it into the PC stall.
- `mem_rd`, out, 1: external read strobe.
- `mem_addr`, out, `MEM_ADDR_W`: external byte address.
- `mem_rdata`, in, 8: external data, valid `WAIT_CYCLES`+1 cycles after `mem_addr`/`mem_rd` are presented.
- `bus_err`, out, 1: sticky error flag. Set by a write attempt or an unaligned fetch; cleared only by reset.

## Operation
- **Line buffer:** `buf_valid`, `buf_tag[29:0]` and `buf_data[31:0]`.
- **Hit condition:** `rom_en` & `buf_valid` & (`buf_tag` == `rom_addr[31:2]`).
- **Outputs (combinational):**
  - `rom_read_data` = `buf_data` on a hit, else 0.
  - `stall_req` = `rom_en` & !hit.
- **FSM states:**
  - **IDLE:** on `rom_en` & !hit, latch `fetch_tag` = `rom_addr[31:2]`, clear `byte_idx` and `wait_cnt`, go to FETCH.
  - **FETCH:** drive `mem_rd` = 1 and `mem_addr` = {`fetch_tag`, `byte_idx`} truncated to `MEM_ADDR_W`.
    - `wait_cnt` counts 0..`WAIT_CYCLES`.
    - When `wait_cnt` == `WAIT_CYCLES`, capture `mem_rdata` into byte lane `byte_idx`, clear `wait_cnt`, and increment `byte_idx`.
    - After lane 3 is captured, go to FILL.
  - **FILL:** write `buf_tag` = `fetch_tag`, set `buf_valid` = 1, return to IDLE.
- **Byte order:** little-endian. Byte at offset 0 goes to bits [7:0]; offset 3 goes to [31:24].
- **Unaligned fetch** (`rom_addr[1:0]` != 0 while `rom_en`): set `bus_err` and serve the aligned word.
- **Write attempt** (`rom_en` & `rom_write_en` != 0): set `bus_err`. No other effect; the read path proceeds normally.
- **`rom_en` low:** no new fetch starts and `stall_req` = 0.
- **`rom_en` drops mid-FETCH:** abort to IDLE, discard partial data, and clear `buf_valid`.
- **`rom_addr` changes mid-FETCH** (protocol violation): the fill completes for `fetch_tag`. The new address then misses and refetches.
- **`mem_rd`:** 0 in IDLE and FILL.

## Timing
- **Reset** (`rst` = 0 at a clock edge):
  - FSM goes to IDLE; `buf_valid` = 0; `bus_err` = 0.
  - `mem_rd` = 0, `mem_addr` = 0.
  - `rom_read_data` = 0 and `stall_req` = 0 while `rom_en` = 0.
  - Reset mid-FETCH aborts the fetch without completing it.
- **Hit:** zero added latency; data is valid in the same cycle as `rom_addr`.
- **Miss stall length:** 1 cycle (IDLE detect) + 4×(`WAIT_CYCLES`+1) cycles (FETCH) + 1 cycle (FILL).
  - `stall_req` is high for that whole period.
  - It falls combinationally in the cycle after FILL, with `rom_read_data` valid.
  - With `WAIT_CYCLES` = 2, the stall lasts 14 cycles.
- **Bus timing:** `mem_addr` changes only on the capture edge. Each byte address is held for exactly `WAIT_CYCLES`+1 cycles.
- **Buffer and flag updates:** registered. A refill overwrites the buffer only in FILL, so the old word stays readable until then. `bus_err` is set on the edge after the offending cycle.

## Structure
- Bus widths `ADDR_BUS`, `DATA_BUS` and `MEM_SEL_BUS` come from the shared bus include.
- Add `ROM_BRIDGE_IDLE`, `ROM_BRIDGE_FETCH` and `ROM_BRIDGE_FILL` (2-bit state codes) to a shared `rom_bridge.v` include.
- Single module; no sub-module is warranted.

## Test plan
1. **Reset and idle:** hold `rst` = 0 for 3 cycles with `rom_en` = 0, then release. Require `stall_req` = 0, `mem_rd` = 0, `bus_err` = 0.
2. **Cold miss then hit:** `WAIT_CYCLES` = 2; ROM bytes 0x00..0x03 = 0x78, 0x56, 0x34, 0x12; `rom_addr` = 0x00000000.
   - `stall_req` high for exactly 14 cycles.
   - `mem_addr` steps 0,1,2,3 with each held 3 cycles.
   - Then `rom_read_data` = 0x12345678 with `stall_req` = 0.
3. **Sequential fetch:** PC advances to 0x4 after the hit. Require one new 14-cycle miss. Then re-present 0x4 and require an immediate hit with no stall.
4. **Error flags:** one fetch with `rom_write_en` = 4'b1111, then one with `rom_addr` = 0x2. Require `bus_err` = 1 after each, sticky until reset, and the aligned word returned for 0x2.
5. **Abort:** drop `rom_en` at byte 2 of a fill. Require immediate return to IDLE, `mem_rd` = 0 and `buf_valid` cleared. Re-asserting `rom_en` at the same address causes a full 14-cycle miss.
6. **Reset mid-fetch:** `rst` = 0 during FETCH. Require IDLE, `mem_rd` = 0 and `buf_valid` = 0 on the next edge; no FILL occurs.

Source files
------------

// File: rtl/inst_rom_bridge_pkg.sv
// Shared bus widths, state codes and line-buffer payload for the instruction-ROM bridge.
package inst_rom_bridge_pkg;

    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned TAG_W       = ADDR_BUS - 2;
    localparam int unsigned LANE_W      = 2;
    localparam int unsigned WAIT_W      = 4;

    typedef enum logic [1:0] {
        ROM_BRIDGE_IDLE  = 2'd0,
        ROM_BRIDGE_FETCH = 2'd1,
        ROM_BRIDGE_FILL  = 2'd2
    } rom_bridge_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [DATA_BUS-1:0] data;
    } line_buf_t;

    // Word tag of a byte address (drops the byte offset).
    function automatic logic [TAG_W-1:0] word_tag(input logic [ADDR_BUS-1:0] addr);
        return addr[ADDR_BUS-1:2];
    endfunction

endpackage

// File: rtl/inst_rom_bridge.sv
// Instruction-ROM responder: one-word line buffer filled from a byte-wide,
// fixed-latency external ROM; stalls the fetch stage on a miss.
module inst_rom_bridge
    import inst_rom_bridge_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W  = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_en,
    input  logic [MEM_SEL_BUS-1:0] rom_write_en,
    input  logic [ADDR_BUS-1:0]    rom_addr,
    input  logic [DATA_BUS-1:0]    rom_write_data,
    output logic [DATA_BUS-1:0]    rom_read_data,
    output logic                   stall_req,
    output logic                   mem_rd,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [BYTE_W-1:0]      mem_rdata,
    output logic                   bus_err
);

    rom_bridge_state_e   state_q, state_d;
    line_buf_t           buf_q, buf_d;
    logic [TAG_W-1:0]    fetch_tag_q, fetch_tag_d;
    logic [LANE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_BUS-1:0] line_q, line_d;
    logic                bus_err_q, bus_err_d;
    logic                hit_c;
    logic                unused_wdata;

    // The ROM is read-only; write data is never consumed.
    assign unused_wdata = ^rom_write_data;

    assign hit_c         = rom_en & buf_q.valid & (buf_q.tag == word_tag(rom_addr));
    assign rom_read_data = hit_c ? buf_q.data : '0;
    assign stall_req     = rom_en & ~hit_c;
    assign mem_rd        = (state_q == ROM_BRIDGE_FETCH);
    assign mem_addr      = MEM_ADDR_W'({fetch_tag_q, byte_idx_q});
    assign bus_err       = bus_err_q;

    // Next-state logic; assembled bytes only reach the buffer in FILL.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fetch_tag_d = fetch_tag_q;
        byte_idx_d  = byte_idx_q;
        wait_cnt_d  = wait_cnt_q;
        line_d      = line_q;
        bus_err_d   = bus_err_q
                    | (rom_en & ((rom_write_en != '0) | (rom_addr[1:0] != 2'b00)));

        unique case (state_q)
            ROM_BRIDGE_IDLE: begin
                if (rom_en && !hit_c) begin
                    fetch_tag_d = word_tag(rom_addr);
                    byte_idx_d  = '0;
                    wait_cnt_d  = '0;
                    state_d     = ROM_BRIDGE_FETCH;
                end
            end
            ROM_BRIDGE_FETCH: begin
                if (!rom_en) begin
                    buf_d.valid = 1'b0;
                    byte_idx_d  = '0;
                    wait_cnt_d  = '0;
                    state_d     = ROM_BRIDGE_IDLE;
                end else if (wait_cnt_q == WAIT_W'(WAIT_CYCLES)) begin
                    line_d[{byte_idx_q, 3'b000} +: BYTE_W] = mem_rdata;
                    wait_cnt_d = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = ROM_BRIDGE_FILL;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ROM_BRIDGE_FILL: begin
                buf_d.valid = 1'b1;
                buf_d.tag   = fetch_tag_q;
                buf_d.data  = line_q;
                state_d     = ROM_BRIDGE_IDLE;
            end
            default: begin
                state_d = ROM_BRIDGE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ROM_BRIDGE_IDLE;
            buf_q       <= '0;
            fetch_tag_q <= '0;
            byte_idx_q  <= '0;
            wait_cnt_q  <= '0;
            line_q      <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fetch_tag_q <= fetch_tag_d;
            byte_idx_q  <= byte_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            line_q      <= line_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule
